// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Optional fetch buffer is enabled by defining MEM_ARB_IBUF_EN.
package mem_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_WAIT = 2'd1,
    ST_ME_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Which requester owns the current transaction / RESP pulse
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_ME = 1'b1
  } owner_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_ibuf.sv
// One-entry fetch buffer (tag, data, valid) used by mem_arbiter when
// MEM_ARB_IBUF_EN is defined. Filled on completed IF reads, invalidated
// by an ME write to the buffered address.
module mem_arb_ibuf
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_fill_tag,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_inv,
  input  logic [DATA_W-1:0] i_inv_addr,
  input  logic [DATA_W-1:0] i_lookup_addr,
  output logic              o_hit_c,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  // Entry update: fill wins, otherwise invalidate on a matching write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_inv && r_valid && (i_inv_addr == r_tag)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit_c = r_valid && (r_tag == i_lookup_addr);
  assign o_data  = r_data;

endmodule : mem_arb_ibuf

// File: rtl/mem_arbiter.sv
// Fixed-priority (ME over IF) arbiter in front of a single-port unified
// memory, with a saturating IF-stall counter.
// Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer (mem_arb_ibuf).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // memory-stage requester
  input  logic              me_req,
  input  logic              me_we,
  input  logic [DATA_W-1:0] me_addr,
  input  logic [DATA_W-1:0] me_wdata,
  output logic [DATA_W-1:0] me_rdata,
  output logic              me_ready,
  // unified memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // performance
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            r_state,     w_state_nxt;
  owner_t            r_owner,     w_owner_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [DATA_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_if_ready,  w_if_ready_nxt;
  logic              r_me_ready,  w_me_ready_nxt;
  logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic [DATA_W-1:0] r_me_rdata,  w_me_rdata_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, w_stall_cnt_nxt;

  logic              w_ibuf_hit;
  logic [DATA_W-1:0] w_ibuf_data;
  logic              w_stall_cycle;

`ifdef MEM_ARB_IBUF_EN
  logic w_ibuf_fill;
  logic w_ibuf_inv;

  // Fill on a completed IF read; invalidate when an ME write is granted
  assign w_ibuf_fill = (r_state == ST_IF_WAIT) && mem_ack;
  assign w_ibuf_inv  = (r_state == ST_IDLE) && me_req && me_we;

  mem_arb_ibuf #(
    .DATA_W (DATA_W)
  ) u_ibuf (
    .clk           (clk),
    .rst           (rst),
    .i_fill        (w_ibuf_fill),
    .i_fill_tag    (r_mem_addr),
    .i_fill_data   (mem_rdata),
    .i_inv         (w_ibuf_inv),
    .i_inv_addr    (me_addr),
    .i_lookup_addr (if_addr),
    .o_hit_c       (w_ibuf_hit),
    .o_data        (w_ibuf_data)
  );
`else
  assign w_ibuf_hit  = 1'b0;
  assign w_ibuf_data = '0;
`endif

  // IF is stalled while ME holds the memory, including ME's RESP cycle
  assign w_stall_cycle = if_req &&
                         ((r_state == ST_ME_WAIT) ||
                          ((r_state == ST_RESP) && (r_owner == OWN_ME)));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ready_nxt  = 1'b0;
    w_me_ready_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_me_rdata_nxt  = r_me_rdata;
    w_stall_cnt_nxt = r_stall_cnt;

    case (r_state)
      ST_IDLE: begin
        if (me_req) begin
          w_state_nxt     = ST_ME_WAIT;
          w_owner_nxt     = OWN_ME;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = me_we;
          w_mem_addr_nxt  = me_addr;
          w_mem_wdata_nxt = me_wdata;
        end else if (if_req && w_ibuf_hit) begin
          w_state_nxt    = ST_RESP;
          w_owner_nxt    = OWN_IF;
          w_if_ready_nxt = 1'b1;
          w_if_rdata_nxt = w_ibuf_data;
        end else if (if_req) begin
          w_state_nxt     = ST_IF_WAIT;
          w_owner_nxt     = OWN_IF;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr;
          w_mem_wdata_nxt = '0;
        end
      end
      ST_IF_WAIT: begin
        if (mem_ack) begin
          w_state_nxt    = ST_RESP;
          w_mem_req_nxt  = 1'b0;
          w_if_ready_nxt = 1'b1;
          w_if_rdata_nxt = mem_rdata;
        end
      end
      ST_ME_WAIT: begin
        if (mem_ack) begin
          w_state_nxt    = ST_RESP;
          w_mem_req_nxt  = 1'b0;
          w_me_ready_nxt = 1'b1;
          w_me_rdata_nxt = mem_rdata;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase

    if (w_stall_cycle && (r_stall_cnt != {CNT_W{1'b1}})) begin
      w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_me_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_me_rdata  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_me_ready  <= w_me_ready_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_me_rdata  <= w_me_rdata_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign me_ready  = r_me_ready;
  assign if_rdata  = r_if_rdata;
  assign me_rdata  = r_me_rdata;
  assign stall_cnt = r_stall_cnt;

endmodule : mem_arbiter
